// File: rtl/bbox_pixel_scanner_if.sv
// Handshake bundle between the bounding-box stage, the pixel scanner and the
// per-pixel inside-test stage.
interface bbox_pixel_scanner_if;
  logic        box_valid;
  logic        box_ready;
  logic [15:0] xmin;
  logic [15:0] xmax;
  logic [15:0] ymin;
  logic [15:0] ymax;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] pix_x;
  logic [15:0] pix_y;
  logic        pix_last;
  logic        done;
  logic        busy;

  modport master (
    output box_valid, xmin, xmax, ymin, ymax, pix_ready,
    input  box_ready, pix_valid, pix_x, pix_y, pix_last, done, busy
  );

  modport slave (
    input  box_valid, xmin, xmax, ymin, ymax, pix_ready,
    output box_ready, pix_valid, pix_x, pix_y, pix_last, done, busy
  );
endinterface

// File: rtl/bbox_pixel_scanner.sv
// Clips one Q10.6 bounding box to the screen and streams its pixel coordinates
// row-major, one per cycle, over a valid/ready handshake.
module bbox_pixel_scanner #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input logic                  clk,
  input logic                  rst_n,
  bbox_pixel_scanner_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CLIP, SCAN, FIN} state_t;

  localparam logic [15:0] X_LIM     = 16'((SCREEN_W - 1) * 64);
  localparam logic [15:0] Y_LIM     = 16'((SCREEN_H - 1) * 64);
  localparam logic [15:0] INT_MASK  = 16'hFFC0;
  localparam logic [15:0] STEP      = 16'd64;

  state_t      state;
  state_t      state_next;
  logic [15:0] xmin_r;
  logic [15:0] xmax_r;
  logic [15:0] ymin_r;
  logic [15:0] ymax_r;
  logic [15:0] x_r;
  logic [15:0] y_r;
  logic [15:0] xmax_c;
  logic [15:0] ymax_c;
  logic        accept;
  logic        empty;
  logic        pix_fire;
  logic        at_row_end;
  logic        at_box_end;

  // Clipping only ever lowers the max corner; a min corner past it means the
  // box is empty or entirely off-screen.
  assign xmax_c     = (xmax_r > X_LIM) ? X_LIM : xmax_r;
  assign ymax_c     = (ymax_r > Y_LIM) ? Y_LIM : ymax_r;
  assign empty      = (xmin_r > xmax_c) || (ymin_r > ymax_c);

  assign accept     = (state == IDLE) && bus.box_valid;
  assign pix_fire   = (state == SCAN) && bus.pix_ready;
  assign at_row_end = (x_r == xmax_r);
  assign at_box_end = at_row_end && (y_r == ymax_r);

  assign bus.box_ready = (state == IDLE);
  assign bus.pix_valid = (state == SCAN);
  assign bus.pix_x     = x_r;
  assign bus.pix_y     = y_r;
  assign bus.pix_last  = (state == SCAN) && at_box_end;
  assign bus.done      = (state == FIN);
  assign bus.busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = CLIP;
      CLIP: state_next = empty ? FIN : SCAN;
      SCAN: if (pix_fire && at_box_end) state_next = FIN;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // In CLIP the max corners are overwritten with their clipped values so the
  // scan loop compares against registers rather than the clamp logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xmin_r <= '0;
      xmax_r <= '0;
      ymin_r <= '0;
      ymax_r <= '0;
      x_r    <= '0;
      y_r    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            xmin_r <= bus.xmin & INT_MASK;
            xmax_r <= bus.xmax & INT_MASK;
            ymin_r <= bus.ymin & INT_MASK;
            ymax_r <= bus.ymax & INT_MASK;
          end
        end
        CLIP: begin
          xmax_r <= xmax_c;
          ymax_r <= ymax_c;
          x_r    <= xmin_r;
          y_r    <= ymin_r;
        end
        SCAN: begin
          if (pix_fire) begin
            if (!at_row_end) begin
              x_r <= x_r + STEP;
            end else if (!at_box_end) begin
              x_r <= xmin_r;
              y_r <= y_r + STEP;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bbox_pixel_scanner.sv
// Scoreboard bench for bbox_pixel_scanner: a coordinate-index model queues the
// expected pixels, which are popped and compared as the DUT hands them over.
module tb_bbox_pixel_scanner;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        last;
  } pix_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passes = 0;
  pix_t exp_q[$];

  bbox_pixel_scanner_if bus ();

  bbox_pixel_scanner #(
    .SCREEN_W(SCREEN_W),
    .SCREEN_H(SCREEN_H)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Model works in whole-pixel indices and clips with the screen size.
  task automatic push_expected(input logic [15:0] bx0, input logic [15:0] bx1,
                               input logic [15:0] by0, input logic [15:0] by1);
    int   x0, x1, y0, y1;
    pix_t p;
    x0 = int'(bx0) / 64;
    x1 = int'(bx1) / 64;
    y0 = int'(by0) / 64;
    y1 = int'(by1) / 64;
    if (x1 > SCREEN_W - 1) x1 = SCREEN_W - 1;
    if (y1 > SCREEN_H - 1) y1 = SCREEN_H - 1;
    for (int yy = y0; yy <= y1; yy++) begin
      for (int xx = x0; xx <= x1; xx++) begin
        p.x    = 16'(xx * 64);
        p.y    = 16'(yy * 64);
        p.last = (xx == x1) && (yy == y1);
        exp_q.push_back(p);
      end
    end
  endtask

  // Presents a box for one edge; returns at the negedge of the CLIP cycle.
  task automatic send_box(input logic [15:0] bx0, input logic [15:0] bx1,
                          input logic [15:0] by0, input logic [15:0] by1);
    bus.box_valid = 1'b1;
    bus.xmin = bx0;
    bus.xmax = bx1;
    bus.ymin = by0;
    bus.ymax = by1;
    @(posedge clk);
    @(negedge clk);
    bus.box_valid = 1'b0;
  endtask

  // Scans one box; rpat[k%4] drives pix_ready, hold_bv keeps a junk box
  // offered during the scan to prove it is ignored.
  task automatic run_box(input string name,
                         input logic [15:0] bx0, input logic [15:0] bx1,
                         input logic [15:0] by0, input logic [15:0] by1,
                         input logic [3:0] rpat, input bit hold_bv);
    int   cyc, k, npix, first_cyc, last_cyc, done_cyc, exp_done;
    bit   have_prev, prev_taken;
    pix_t prev, e;
    exp_q.delete();
    push_expected(bx0, bx1, by0, by1);
    npix = exp_q.size();
    bus.pix_ready = rpat[0];
    send_box(bx0, bx1, by0, by1);
    checks++;
    if (bus.busy !== 1'b1 || bus.box_ready !== 1'b0 || bus.pix_valid !== 1'b0) begin
      $display("[TB] FAIL %s clip_cycle busy=%b ready=%b pvalid=%b required 1/0/0",
               name, bus.busy, bus.box_ready, bus.pix_valid);
    end else passes++;
    cyc = 1; k = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1;
    have_prev = 0; prev_taken = 0;
    prev = '{x: '0, y: '0, last: 1'b0};
    while (cyc < 300 && done_cyc < 0) begin
      @(negedge clk);
      cyc++;
      bus.pix_ready = rpat[k % 4];
      k++;
      bus.box_valid = hold_bv;
      bus.xmin = 16'h1000; bus.xmax = 16'h2000;
      bus.ymin = 16'h1000; bus.ymax = 16'h2000;
      if (bus.done) begin
        done_cyc = cyc;
        bus.box_valid = 1'b0;
      end
      if (bus.pix_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (have_prev && !prev_taken) begin
          checks++;
          if (bus.pix_x !== prev.x || bus.pix_y !== prev.y || bus.pix_last !== prev.last) begin
            $display("[TB] FAIL %s stall_hold got (%0d,%0d,%b) required (%0d,%0d,%b)",
                     name, bus.pix_x, bus.pix_y, bus.pix_last, prev.x, prev.y, prev.last);
          end else passes++;
        end
        if (bus.pix_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            $display("[TB] FAIL %s extra_pixel got (%0d,%0d) required none",
                     name, bus.pix_x, bus.pix_y);
          end else begin
            e = exp_q.pop_front();
            if (bus.pix_x !== e.x || bus.pix_y !== e.y || bus.pix_last !== e.last) begin
              $display("[TB] FAIL %s pixel got (%0d,%0d,%b) required (%0d,%0d,%b)",
                       name, bus.pix_x, bus.pix_y, bus.pix_last, e.x, e.y, e.last);
            end else passes++;
          end
          last_cyc = cyc;
        end
        prev = '{x: bus.pix_x, y: bus.pix_y, last: bus.pix_last};
        prev_taken = bus.pix_ready;
        have_prev = 1;
      end else if (bus.pix_last) begin
        checks++;
        $display("[TB] FAIL %s last_without_valid got 1 required 0", name);
      end
    end
    bus.box_valid = 1'b0;
    exp_done = (npix == 0) ? 2 : last_cyc + 1;
    checks++;
    if (done_cyc !== exp_done) begin
      $display("[TB] FAIL %s done_cycle got %0d required %0d", name, done_cyc, exp_done);
    end else passes++;
    checks++;
    if (exp_q.size() != 0) begin
      $display("[TB] FAIL %s missing_pixels got %0d left required 0", name, exp_q.size());
    end else passes++;
    if (npix > 0) begin
      checks++;
      if (first_cyc != 2) begin
        $display("[TB] FAIL %s first_pixel_cycle got %0d required 2", name, first_cyc);
      end else passes++;
    end
    if (rpat == 4'hF && npix > 0) begin
      checks++;
      if (last_cyc != 1 + npix) begin
        $display("[TB] FAIL %s last_pixel_cycle got %0d required %0d", name, last_cyc, 1 + npix);
      end else passes++;
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.box_ready !== 1'b1 || bus.busy !== 1'b0) begin
      $display("[TB] FAIL %s after_done done=%b ready=%b busy=%b required 0/1/0",
               name, bus.done, bus.box_ready, bus.busy);
    end else passes++;
  endtask

  task automatic test_reset;
    checks++;
    if (bus.box_ready !== 1'b1 || bus.pix_valid !== 1'b0 || bus.pix_last !== 1'b0 ||
        bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      $display("[TB] FAIL reset_flags ready=%b valid=%b last=%b done=%b busy=%b required 1/0/0/0/0",
               bus.box_ready, bus.pix_valid, bus.pix_last, bus.done, bus.busy);
    end else passes++;
    checks++;
    if (bus.pix_x !== 16'd0 || bus.pix_y !== 16'd0) begin
      $display("[TB] FAIL reset_coords got (%0d,%0d) required (0,0)", bus.pix_x, bus.pix_y);
    end else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    run_box("basic", 16'd128, 16'd192, 16'd64, 16'd128, 4'b1111, 1'b0);
  endtask

  task automatic test_stall;
    run_box("stall", 16'd128, 16'd192, 16'd64, 16'd128, 4'b1001, 1'b0);
  endtask

  task automatic test_single_pixel;
    run_box("single", 16'd320 | 16'h15, 16'd320 | 16'h15,
            16'd640 | 16'h15, 16'd640 | 16'h15, 4'b1111, 1'b0);
  endtask

  task automatic test_empty;
    run_box("empty", 16'd256, 16'd192, 16'd0, 16'd64, 4'b1111, 1'b0);
  endtask

  task automatic test_clip;
    run_box("clip", 16'd40832, 16'hFFC0, 16'd0, 16'd0, 4'b1111, 1'b0);
  endtask

  task automatic test_ignore_busy_box;
    run_box("ignore_busy", 16'd0, 16'd128, 16'd0, 16'd64, 4'b1011, 1'b1);
  endtask

  task automatic test_back_to_back;
    run_box("b2b_a", 16'd64, 16'd64, 16'd64, 16'd192, 4'b1111, 1'b0);
    run_box("b2b_b", 16'd192, 16'd320, 16'd128, 16'd128, 4'b1111, 1'b0);
  endtask

  task automatic test_reset_mid_scan;
    int   taken;
    pix_t e;
    exp_q.delete();
    push_expected(16'd64, 16'd192, 16'd0, 16'd128);
    bus.pix_ready = 1'b1;
    send_box(16'd64, 16'd192, 16'd0, 16'd128);
    taken = 0;
    for (int c = 0; c < 20 && taken < 4; c++) begin
      @(negedge clk);
      if (bus.pix_valid && bus.pix_ready) begin
        e = exp_q.pop_front();
        taken++;
        checks++;
        if (bus.pix_x !== e.x || bus.pix_y !== e.y) begin
          $display("[TB] FAIL rst_scan pixel got (%0d,%0d) required (%0d,%0d)",
                   bus.pix_x, bus.pix_y, e.x, e.y);
        end else passes++;
      end
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.pix_valid !== 1'b0 || bus.busy !== 1'b0 || bus.box_ready !== 1'b1 ||
        bus.pix_x !== 16'd0 || bus.pix_y !== 16'd0) begin
      $display("[TB] FAIL async_reset valid=%b busy=%b ready=%b xy=(%0d,%0d) required 0/0/1/(0,0)",
               bus.pix_valid, bus.busy, bus.box_ready, bus.pix_x, bus.pix_y);
    end else passes++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        $display("[TB] FAIL post_reset_idle done=%b busy=%b required 0/0", bus.done, bus.busy);
      end else passes++;
    end
    exp_q.delete();
    run_box("after_reset", 16'd256, 16'd320, 16'd192, 16'd256, 4'b1111, 1'b0);
  endtask

  initial begin
    bus.box_valid = 1'b0;
    bus.xmin = '0;
    bus.xmax = '0;
    bus.ymin = '0;
    bus.ymax = '0;
    bus.pix_ready = 1'b0;
    #12;
    test_reset();
    test_basic();
    test_stall();
    test_single_pixel();
    test_empty();
    test_clip();
    test_ignore_busy_box();
    test_back_to_back();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
